// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blanking,
// line/frame strobes and a free-running frame counter, advancing on pix_en.
module vga_sync_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_active,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_reg, h_next;
  logic [9:0] v_reg, v_next;
  logic       hsync_reg, vsync_reg, active_reg;
  logic       line_start_reg, frame_start_reg;
  logic [9:0] frame_count_reg;

  logic hs_on_next, vs_on_next, active_next, line_wrap_next, frame_wrap_next;

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = '0;
      if (v_reg == V_LAST) v_next = '0;
      else                 v_next = v_reg + 10'd1;
    end else begin
      h_next = h_reg + 10'd1;
    end
  end

  // Decode from the next-state counters so the registered outputs line up
  // with the pix_x/pix_y presented in the same cycle.
  always_comb begin
    hs_on_next      = (h_next >= H_SYNC_BEG) && (h_next <= H_SYNC_END);
    vs_on_next      = (v_next >= V_SYNC_BEG) && (v_next <= V_SYNC_END);
    active_next     = (h_next < H_VIS) && (v_next < V_VIS);
    line_wrap_next  = (h_next == 10'd0);
    frame_wrap_next = (h_next == 10'd0) && (v_next == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg           <= H_LAST;
      v_reg           <= V_LAST;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      active_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= 10'h3FF;
    end else begin
      // Strobes are single-clk pulses even when pix_en stalls.
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      if (pix_en) begin
        h_reg           <= h_next;
        v_reg           <= v_next;
        hsync_reg       <= hs_on_next ? HSYNC_POL : ~HSYNC_POL;
        vsync_reg       <= vs_on_next ? VSYNC_POL : ~VSYNC_POL;
        active_reg      <= active_next;
        line_start_reg  <= line_wrap_next;
        frame_start_reg <= frame_wrap_next;
        if (frame_wrap_next) frame_count_reg <= frame_count_reg + 10'd1;
      end
    end
  end

  assign pix_x        = h_reg;
  assign pix_y        = v_reg;
  assign hsync        = hsync_reg;
  assign vsync        = vsync_reg;
  assign video_active = active_reg;
  assign line_start   = line_start_reg;
  assign frame_start  = frame_start_reg;
  assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing for reset/line behaviour,
// a medium raster for frame/stall/mid-frame reset, and a tiny raster for wrap.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default timing instance
  logic d_rst = 1'b0, d_en = 1'b0;
  logic d_hs, d_vs, d_va, d_ls, d_fs;
  logic [9:0] d_x, d_y, d_fc;
  vga_sync_gen dut (
    .clk(clk), .rst(d_rst), .pix_en(d_en), .hsync(d_hs), .vsync(d_vs),
    .video_active(d_va), .pix_x(d_x), .pix_y(d_y), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  // medium raster: H 16/2/4/2 (24), V 12/2/2/3 (19), active-high hsync
  logic m_rst = 1'b0, m_en = 1'b0;
  logic m_hs, m_vs, m_va, m_ls, m_fs;
  logic [9:0] m_x, m_y, m_fc;
  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dm (
    .clk(clk), .rst(m_rst), .pix_en(m_en), .hsync(m_hs), .vsync(m_vs),
    .video_active(m_va), .pix_x(m_x), .pix_y(m_y), .line_start(m_ls),
    .frame_start(m_fs), .frame_count(m_fc)
  );

  // tiny raster: H 4/1/1/1 (7), V 2/1/1/1 (5)
  logic s_rst = 1'b0, s_en = 1'b0;
  logic s_hs, s_vs, s_va, s_ls, s_fs;
  logic [9:0] s_x, s_y, s_fc;
  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) ds (
    .clk(clk), .rst(s_rst), .pix_en(s_en), .hsync(s_hs), .vsync(s_vs),
    .video_active(s_va), .pix_x(s_x), .pix_y(s_y), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       hs;
    logic       vs;
    logic       va;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic [9:0] fc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic en, input logic hs,
                              input logic vs, input logic va, input int x,
                              input int y, input logic ls, input logic fs,
                              input int fc);
    vec_t v;
    v.rst = rst; v.en = en; v.hs = hs; v.vs = vs; v.va = va;
    v.x = 10'(x); v.y = 10'(y); v.ls = ls; v.fs = fs; v.fc = 10'(fc);
    return v;
  endfunction

  function automatic logic [35:0] pack_exp(input vec_t v);
    return {v.hs, v.vs, v.va, v.x, v.y, v.ls, v.fs, v.fc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    int va_cnt, hs_cnt, hs_min, hs_max, ls_cnt, ls_tick;
    int vs_low_cnt, vs_rise, rise_x, rise_y, first_low_x, first_low_y;
    int fs_cnt, fs_prev, fs_gap_bad, ls_m_cnt, va_bad, hs_m_cnt;
    int pos_bad, width_bad, strobe_bad, mx, my, fs_c0, fs_c1;
    int max_x, max_y, wraps;
    logic prev_vs, prev_ls, prev_fs;
    logic [9:0] prev_fc;

    // rst, en, hs, vs, va, x, y, ls, fs, fc
    vecs[0]  = mk(1, 1, 1, 1, 0, 799, 524, 0, 0, 1023);
    vecs[1]  = mk(1, 1, 1, 1, 0, 799, 524, 0, 0, 1023);
    vecs[2]  = mk(1, 1, 1, 1, 0, 799, 524, 0, 0, 1023);
    vecs[3]  = mk(0, 1, 1, 1, 1,   0,   0, 1, 1,    0);
    vecs[4]  = mk(0, 0, 1, 1, 1,   0,   0, 0, 0,    0);
    vecs[5]  = mk(0, 0, 1, 1, 1,   0,   0, 0, 0,    0);
    vecs[6]  = mk(0, 1, 1, 1, 1,   1,   0, 0, 0,    0);
    vecs[7]  = mk(1, 0, 1, 1, 0, 799, 524, 0, 0, 1023);
    vecs[8]  = mk(1, 1, 1, 1, 0, 799, 524, 0, 0, 1023);
    vecs[9]  = mk(0, 0, 1, 1, 0, 799, 524, 0, 0, 1023);
    vecs[10] = mk(0, 1, 1, 1, 1,   0,   0, 1, 1,    0);

    for (int i = 0; i < 11; i++) begin
      d_rst = vecs[i].rst;
      d_en  = vecs[i].en;
      tick();
      check($sformatf("vec%0d", i),
            64'({d_hs, d_vs, d_va, d_x, d_y, d_ls, d_fs, d_fc}),
            64'(pack_exp(vecs[i])));
    end

    // one full line at the default timing, starting from (0,0)
    d_en = 1'b1;
    va_cnt = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1; ls_cnt = 0; ls_tick = -1;
    for (int t = 1; t <= 800; t++) begin
      tick();
      if (d_va) va_cnt++;
      if (!d_hs) begin
        hs_cnt++;
        if (int'(d_x) < hs_min) hs_min = int'(d_x);
        if (int'(d_x) > hs_max) hs_max = int'(d_x);
      end
      if (d_ls) begin ls_cnt++; ls_tick = t; end
    end
    d_en = 1'b0;
    check("line_active_ticks", 64'(va_cnt), 64'd640);
    check("line_hsync_ticks", 64'(hs_cnt), 64'd96);
    check("line_hsync_first_x", 64'(hs_min), 64'd656);
    check("line_hsync_last_x", 64'(hs_max), 64'd751);
    check("line_start_count", 64'(ls_cnt), 64'd1);
    check("line_start_period", 64'(ls_tick), 64'd800);
    check("line_end_pos", 64'({d_x, d_y}), 64'({10'd0, 10'd1}));

    // two frames on the medium raster
    m_rst = 1'b1; m_en = 1'b1;
    tick(); tick();
    check("m_reset_state", 64'({m_hs, m_vs, m_va, m_x, m_y, m_ls, m_fs, m_fc}),
          64'({1'b0, 1'b1, 1'b0, 10'd23, 10'd18, 1'b0, 1'b0, 10'h3FF}));
    m_rst = 1'b0;
    prev_vs = m_vs;
    vs_low_cnt = 0; vs_rise = 0; rise_x = -1; rise_y = -1;
    first_low_x = -1; first_low_y = -1;
    fs_cnt = 0; fs_prev = -1; fs_gap_bad = 0; ls_m_cnt = 0; va_cnt = 0;
    va_bad = 0; hs_m_cnt = 0;
    for (int t = 1; t <= 913; t++) begin
      tick();
      if (t <= 912) begin
        if (!m_vs) vs_low_cnt++;
        if (m_va) va_cnt++;
        if (m_hs) hs_m_cnt++;
      end
      if (!m_vs && first_low_x < 0) begin first_low_x = int'(m_x); first_low_y = int'(m_y); end
      if (!prev_vs && m_vs) begin
        vs_rise++;
        if (rise_x < 0) begin rise_x = int'(m_x); rise_y = int'(m_y); end
      end
      prev_vs = m_vs;
      if (m_va != ((m_x < 10'd16) && (m_y < 10'd12))) va_bad++;
      if (m_ls) ls_m_cnt++;
      if (m_fs) begin
        if (fs_prev >= 0 && (t - fs_prev) != 456) fs_gap_bad++;
        fs_prev = t;
        fs_cnt++;
      end
    end
    check("frame_start_count", 64'(fs_cnt), 64'd3);
    check("frame_start_period", 64'(fs_gap_bad), 64'd0);
    check("frame_vsync_low_ticks", 64'(vs_low_cnt), 64'd96);
    check("frame_vsync_start_pos", 64'({first_low_x[9:0], first_low_y[9:0]}), 64'({10'd0, 10'd14}));
    check("frame_vsync_rises", 64'(vs_rise), 64'd2);
    check("frame_vsync_rise_pos", 64'({rise_x[9:0], rise_y[9:0]}), 64'({10'd0, 10'd16}));
    check("frame_active_ticks", 64'(va_cnt), 64'd384);
    check("frame_active_region", 64'(va_bad), 64'd0);
    check("frame_hsync_ticks", 64'(hs_m_cnt), 64'd152);
    check("frame_line_starts", 64'(ls_m_cnt), 64'd39);
    check("frame_count_after2", 64'(m_fc), 64'd2);

    // mid-frame reset at (10,8)
    for (int t = 0; t < 202; t++) tick();
    check("mid_pos", 64'({m_x, m_y, m_va}), 64'({10'd10, 10'd8, 1'b1}));
    m_rst = 1'b1;
    tick();
    check("mid_reset_state", 64'({m_hs, m_vs, m_va, m_x, m_y, m_ls, m_fs, m_fc}),
          64'({1'b0, 1'b1, 1'b0, 10'd23, 10'd18, 1'b0, 1'b0, 10'h3FF}));
    m_rst = 1'b0;
    tick();
    check("mid_restart", 64'({m_hs, m_vs, m_va, m_x, m_y, m_ls, m_fs, m_fc}),
          64'({1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 10'd0}));
    m_en = 1'b0;
    tick();
    check("stall_hold", 64'({m_x, m_y, m_ls, m_fs, m_fc}),
          64'({10'd0, 10'd0, 1'b0, 1'b0, 10'd0}));

    // 1-in-4 pixel enable
    m_rst = 1'b1;
    tick();
    m_rst = 1'b0;
    mx = 23; my = 18; pos_bad = 0; width_bad = 0; strobe_bad = 0;
    fs_c0 = -1; fs_c1 = -1; prev_ls = 1'b0; prev_fs = 1'b0;
    for (int c = 0; c <= 1830; c++) begin
      m_en = ((c % 4) == 0);
      tick();
      if (m_en) begin
        if (mx == 23) begin mx = 0; my = (my == 18) ? 0 : my + 1; end
        else mx = mx + 1;
      end
      if (int'(m_x) != mx || int'(m_y) != my) pos_bad++;
      if ((m_ls && prev_ls) || (m_fs && prev_fs)) width_bad++;
      if (m_ls != (m_en && mx == 0)) strobe_bad++;
      if (m_fs != (m_en && mx == 0 && my == 0)) strobe_bad++;
      if (m_fs) begin
        if (fs_c0 < 0) fs_c0 = c;
        else if (fs_c1 < 0) fs_c1 = c;
      end
      prev_ls = m_ls; prev_fs = m_fs;
    end
    m_en = 1'b0;
    check("stall_positions", 64'(pos_bad), 64'd0);
    check("stall_strobe_width", 64'(width_bad), 64'd0);
    check("stall_strobe_timing", 64'(strobe_bad), 64'd0);
    check("stall_frame_period", 64'(fs_c1 - fs_c0), 64'd1824);

    // frame counter wrap on the tiny raster
    s_rst = 1'b1; s_en = 1'b1;
    tick();
    s_rst = 1'b0;
    tick();
    check("wrap_first", 64'({s_x, s_y, s_fs, s_fc}), 64'({10'd0, 10'd0, 1'b1, 10'd0}));
    max_x = 0; max_y = 0; wraps = 0; fs_cnt = 0; prev_fc = s_fc;
    for (int t = 1; t <= 35875; t++) begin
      tick();
      if (int'(s_x) > max_x) max_x = int'(s_x);
      if (int'(s_y) > max_y) max_y = int'(s_y);
      if (prev_fc == 10'h3FF && s_fc == 10'd0) wraps++;
      if (s_fs) fs_cnt++;
      prev_fc = s_fc;
    end
    s_en = 1'b0;
    check("wrap_count", 64'(wraps), 64'd1);
    check("wrap_frames", 64'(fs_cnt), 64'd1025);
    check("wrap_final_count", 64'(s_fc), 64'd1);
    check("wrap_max_x", 64'(max_x), 64'd6);
    check("wrap_max_y", 64'(max_y), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA output path. Produces the sync, blanking and pixel-coordinate stream consumed by the background pixel generators (`pix_x`, `pix_y`, `video_active`, `vsync`). It also produces line and frame strobes and a free-running frame counter. It runs in the system clock domain and advances one pixel per qualified `pix_en` tick.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HSYNC_POL`, 0: hsync active level (0 = active-low).
- `VSYNC_POL`, 0: vsync active level (0 = active-low).
- Derived: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800); `V_TOTAL` defined the same way (525). Both must be ≤ 1024. Other values are illegal.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pix_en`, in, 1: pixel tick. Counters advance only on edges where it is high.
- `hsync`, out, 1: horizontal sync, at level `HSYNC_POL` when active.
- `vsync`, out, 1: vertical sync, at level `VSYNC_POL` when active.
- `video_active`, out, 1: current position is visible.
- `pix_x`, out, 10: horizontal position, 0..H_TOTAL-1.
- `pix_y`, out, 10: vertical position, 0..V_TOTAL-1.
- `line_start`, out, 1: one-`clk` pulse when `pix_x` becomes 0.
- `frame_start`, out, 1: one-`clk` pulse when (`pix_x`,`pix_y`) becomes (0,0).
- `frame_count`, out, 10: frame number, wraps modulo 1024.

## Operation

- Two counters, `h` and `v`. `pix_x` = `h` and `pix_y` = `v`; the counter registers drive these ports directly.
- On an edge with `pix_en`=1:
  - If `h` = H_TOTAL-1, then `h` ← 0. In the same case, if `v` = V_TOTAL-1 then `v` ← 0, else `v` ← `v`+1.
  - Otherwise `h` ← `h`+1.
- `hsync`, `vsync` and `video_active` are registers loaded from the next-state counter values. They are therefore always consistent with the `pix_x`/`pix_y` presented in the same cycle:
  - `video_active` = (`h` < H_ACTIVE) && (`v` < V_ACTIVE).
  - hsync is active for `h` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - vsync is active for `v` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491], across the full line width.
- `line_start` is set on an advance into `h`=0 and cleared on the next `clk` edge, regardless of `pix_en`.
- `frame_start` behaves the same way for an advance into (0,0). It always coincides with a `line_start` pulse.
- `frame_count` increments, wrapping 1023→0, on the same edge that sets `frame_start`.
- With `pix_en`=0, every output holds its value except the two strobes, which fall after one cycle.

## Timing

- Reset values: `h`=H_TOTAL-1 (799), `v`=V_TOTAL-1 (524), `video_active`=0, `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL, `line_start`=0, `frame_start`=0, `frame_count`=10'h3FF.
- First `pix_en` edge after reset: outputs become (0,0), `video_active`=1, `line_start`=`frame_start`=1, `frame_count`=0.
- Latency from counter state to every decoded output is 0 cycles; all outputs change on the same edge.
- Line period is H_TOTAL `pix_en` ticks. Frame period is H_TOTAL×V_TOTAL ticks (420000).
- `rst` has priority over `pix_en`. A mid-frame `rst` returns everything to the reset state on that edge, and the first post-reset advance starts a full frame.
- For the active-low vsync, the rising edge occurs on the advance into `v`=492, `h`=0. That edge is the frame-tick seen by downstream scroll counters: exactly one per frame.

## Test plan

- Reset: assert `rst` for 3 cycles with `pix_en`=1. All outputs must equal the reset values listed above. Release `rst`: the next edge gives `pix_x`=0, `pix_y`=0, both strobes high for exactly 1 cycle, `frame_count`=0.
- Line: run `pix_en`=1 continuously for 1 line.
  - `video_active` is high for 640 ticks.
  - `hsync` is low exactly for `pix_x` 656..751 (96 ticks).
  - `line_start` pulses every 800 ticks.
- Frame: run 2 frames.
  - `frame_start` pulses are 420000 ticks apart.
  - `vsync` is low for 1600 ticks, starting at (0,490).
  - There is exactly 1 rising `vsync` per frame.
  - `video_active` is never high for `pix_y` ≥ 480.
- Stall: drive `pix_en` at a 1-in-4 duty.
  - Positions advance once per tick.
  - Strobes are 1 `clk` wide.
  - Frame period is 1680000 `clk` cycles.
- Mid-frame reset: assert `rst` at (300,200). Outputs return to the reset values on that edge, and the next advance gives (0,0) with `frame_start`.
- Wrap, using small params (H 4/1/1/1, V 2/1/1/1): after 1025 frames, `frame_count` has gone 1023→0 once, and `pix_x`/`pix_y` never exceed 6/4.
